hol_col_xlate: RTL and testbench

//  Hollerith-to-EBCDIC column translator, the stage downstream of the 12-row punch decoder.
//  It accepts one 12-row card column per valid/ready transfer, classifies the zone rows
//  (12/11/0) and digit rows (1-9), and emits one EBCDIC byte per column through a 2-stage

---
 rtl/hol_col_xlate.sv | 172 +++++++++++++++++
 tb/tb_hol_col_xlate.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hol_col_xlate.sv
// Hollerith-to-EBCDIC column translator: one 12-row card column in, one EBCDIC byte out,
// through a two-stage valid/ready pipeline with last-column marking and an invalid-punch counter.
module hol_col_xlate #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ERRW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic [11:0]     i_col,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [7:0]      o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_last,
  output logic            o_err,
  output logic [ERRW-1:0] o_errcnt
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LASTCOL = CW'(COLS - 1);

  // Enum encoding equals the {row12,row11,row0} punch bits.
  typedef enum logic [2:0] {
    Z_NONE    = 3'b000,
    Z_0       = 3'b001,
    Z_11      = 3'b010,
    Z_11_0    = 3'b011,
    Z_12      = 3'b100,
    Z_12_0    = 3'b101,
    Z_12_11   = 3'b110,
    Z_12_11_0 = 3'b111
  } zone_t;

  logic [3:0] pop, sel;
  logic [3:0] in_d;
  logic       in_eight, in_derr;

  logic          s1v, s1eight, s1derr, s1last;
  zone_t         s1zone;
  logic [3:0]    s1d;
  logic          s2v, s2err, s2last;
  logic [7:0]    s2data;
  logic [CW-1:0] cnt;
  logic [ERRW-1:0] errcnt;

  logic [7:0] xl_byte, xl_data;
  logic       xl_bad, xl_err;
  logic       out_fire, s2_open, s1_move, in_fire;

  // Digit rows 1..9 live in i_col[8:0] with row r at bit 9-r; row 8 is bit 1.
  always_comb begin
    pop = '0;
    sel = '0;
    for (int unsigned r = 1; r <= 9; r++) begin
      pop = pop + {3'b000, i_col[9-r]};
      if (r != 8 && i_col[9-r]) sel = 4'(r);
    end
    in_d     = '0;
    in_eight = 1'b0;
    in_derr  = 1'b0;
    if (pop == 4'd0) begin
      in_d = '0;
    end else if (pop == 4'd1) begin
      in_d = i_col[1] ? 4'd8 : sel;
    end else if (pop == 4'd2 && i_col[1] && sel >= 4'd2 && sel <= 4'd7) begin
      in_eight = 1'b1;
      in_d     = sel;
    end else begin
      in_derr = 1'b1;
    end
  end

  always_comb begin
    xl_byte = '0;
    xl_bad  = 1'b0;
    if (s1eight) begin
      case (s1zone)
        Z_NONE:  xl_byte = 8'h78 + {4'h0, s1d};
        Z_12:    xl_byte = 8'h48 + {4'h0, s1d};
        Z_11:    xl_byte = 8'h58 + {4'h0, s1d};
        Z_0:     xl_byte = 8'h68 + {4'h0, s1d};
        default: xl_bad  = 1'b1;
      endcase
    end else begin
      case (s1zone)
        Z_NONE:  xl_byte = (s1d == 4'd0) ? 8'h40 : {4'hF, s1d};
        Z_12:    xl_byte = (s1d == 4'd0) ? 8'h50 : {4'hC, s1d};
        Z_11:    xl_byte = (s1d == 4'd0) ? 8'h60 : {4'hD, s1d};
        Z_0: begin
          if (s1d == 4'd0)      xl_byte = 8'hF0;
          else if (s1d == 4'd1) xl_byte = 8'h61;
          else                  xl_byte = {4'hE, s1d};
        end
        Z_12_0: begin
          xl_bad  = (s1d == 4'd0);
          xl_byte = {4'h8, s1d};
        end
        Z_12_11: begin
          xl_bad  = (s1d == 4'd0);
          xl_byte = {4'h9, s1d};
        end
        Z_11_0: begin
          xl_bad  = (s1d <= 4'd1);
          xl_byte = {4'hA, s1d};
        end
        default: xl_bad = 1'b1;
      endcase
    end
    xl_err  = xl_bad | s1derr;
    xl_data = xl_err ? 8'h3F : xl_byte;
  end

  assign out_fire = s2v & i_ready;
  assign s2_open  = ~s2v | i_ready;
  assign s1_move  = s1v & s2_open;
  assign o_ready  = ~s1v | s2_open;
  assign in_fire  = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1v     <= 1'b0;
      s1zone  <= Z_NONE;
      s1d     <= '0;
      s1eight <= 1'b0;
      s1derr  <= 1'b0;
      s1last  <= 1'b0;
      s2v     <= 1'b0;
      s2data  <= '0;
      s2err   <= 1'b0;
      s2last  <= 1'b0;
      cnt     <= '0;
      errcnt  <= '0;
    end else begin
      // The counter sees the departing column even when a restart empties the pipe.
      if (out_fire && s2err && errcnt != '1) errcnt <= errcnt + 1'b1;
      if (i_clr) begin
        s1v <= 1'b0;
        s2v <= 1'b0;
        cnt <= '0;
      end else begin
        if (in_fire) begin
          s1v     <= 1'b1;
          s1zone  <= zone_t'(i_col[11:9]);
          s1d     <= in_d;
          s1eight <= in_eight;
          s1derr  <= in_derr;
          s1last  <= (cnt == LASTCOL);
          cnt     <= (cnt == LASTCOL) ? '0 : cnt + 1'b1;
        end else if (s1_move) begin
          s1v <= 1'b0;
        end
        if (s1_move) begin
          s2v    <= 1'b1;
          s2data <= xl_data;
          s2err  <= xl_err;
          s2last <= s1last;
        end else if (out_fire) begin
          s2v <= 1'b0;
        end
      end
    end
  end

  assign o_valid  = s2v;
  assign o_data   = s2data;
  assign o_err    = s2err;
  assign o_last   = s2last;
  assign o_errcnt = errcnt;

endmodule

// File: tb/tb_hol_col_xlate.sv
// Directed bench for hol_col_xlate: translation table plus handshake, last, clear and reset sequences.
module tb_hol_col_xlate;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_clr, i_valid, i_ready;
  logic [11:0] i_col;
  logic       o_ready, o_valid, o_last, o_err;
  logic [7:0] o_data;
  logic [3:0] o_errcnt;

  always #5 i_clk = ~i_clk;

  hol_col_xlate #(.COLS(4), .ERRW(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_col(i_col),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_last(o_last), .o_err(o_err), .o_errcnt(o_errcnt)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] col;
    logic [7:0]  data;
    logic        err;
  } vec_t;

  vec_t tbl[28];
  logic [11:0] scol[32];
  logic [7:0]  sdat[32];
  logic        serr[32];
  logic        slast[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0; i_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_col = '0;
    tick;
    tick;
    i_rst_n = 1'b1;
  endtask

  // Back-to-back columns with i_ready held high; output k-1 is expected after the k-th edge.
  task automatic run_stream(input int n, input string tag);
    for (int k = 0; k <= n; k++) begin
      i_ready = 1'b1;
      i_valid = (k < n);
      if (k < n) i_col = scol[k];
      tick;
      if (k == 0) begin
        check($sformatf("%s.lat", tag), 32'(o_valid), 32'd0);
      end else begin
        check($sformatf("%s.valid%0d", tag, k-1), 32'(o_valid), 32'd1);
        check($sformatf("%s.data%0d", tag, k-1), 32'(o_data), 32'(sdat[k-1]));
        check($sformatf("%s.err%0d", tag, k-1), 32'(o_err), 32'(serr[k-1]));
        check($sformatf("%s.last%0d", tag, k-1), 32'(o_last), 32'(slast[k-1]));
      end
    end
    i_valid = 1'b0;
    tick;
    check($sformatf("%s.idle", tag), 32'(o_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nerr;
    int n, m;
    logic acc, fire;
    logic [11:0] bc[6];

    tbl[0]  = '{12'h000, 8'h40, 1'b0};
    tbl[1]  = '{12'h800, 8'h50, 1'b0};
    tbl[2]  = '{12'h400, 8'h60, 1'b0};
    tbl[3]  = '{12'h200, 8'hF0, 1'b0};
    tbl[4]  = '{12'h900, 8'hC1, 1'b0};
    tbl[5]  = '{12'h401, 8'hD9, 1'b0};
    tbl[6]  = '{12'h280, 8'hE2, 1'b0};
    tbl[7]  = '{12'h300, 8'h61, 1'b0};
    tbl[8]  = '{12'hA00, 8'h3F, 1'b1};
    tbl[9]  = '{12'hA01, 8'h89, 1'b0};
    tbl[10] = '{12'hC04, 8'h97, 1'b0};
    tbl[11] = '{12'h604, 8'hA7, 1'b0};
    tbl[12] = '{12'h700, 8'h3F, 1'b1};
    tbl[13] = '{12'h082, 8'h7A, 1'b0};
    tbl[14] = '{12'h822, 8'h4C, 1'b0};
    tbl[15] = '{12'h406, 8'h5F, 1'b0};
    tbl[16] = '{12'h242, 8'h6B, 1'b0};
    tbl[17] = '{12'h002, 8'hF8, 1'b0};
    tbl[18] = '{12'h003, 8'h3F, 1'b1};
    tbl[19] = '{12'h102, 8'h3F, 1'b1};
    tbl[20] = '{12'hA82, 8'h3F, 1'b1};
    tbl[21] = '{12'hE00, 8'h3F, 1'b1};
    tbl[22] = '{12'h180, 8'h3F, 1'b1};
    tbl[23] = '{12'hF00, 8'h3F, 1'b1};
    tbl[24] = '{12'hC02, 8'h98, 1'b0};
    tbl[25] = '{12'h201, 8'hE9, 1'b0};
    tbl[26] = '{12'h010, 8'hF5, 1'b0};
    tbl[27] = '{12'h0C2, 8'h3F, 1'b1};

    // Reset state
    do_reset;
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.data", 32'(o_data), 32'h00);
    check("rst.last", 32'(o_last), 32'd0);
    check("rst.err", 32'(o_err), 32'd0);
    check("rst.errcnt", 32'(o_errcnt), 32'd0);
    check("rst.ready", 32'(o_ready), 32'd1);

    // Translation table, one column at a time
    nerr = 0;
    for (int i = 0; i < 28; i++) begin
      scol[0]  = tbl[i].col;
      sdat[0]  = tbl[i].data;
      serr[0]  = tbl[i].err;
      slast[0] = ((i % 4) == 3);
      if (tbl[i].err) nerr++;
      run_stream(1, $sformatf("tbl%0d", i));
    end
    check("tbl.errcnt", 32'(o_errcnt), 32'(nerr));

    // Consecutive stream including invalid columns
    do_reset;
    scol[0] = 12'h900; sdat[0] = 8'hC1; serr[0] = 1'b0;
    scol[1] = 12'h401; sdat[1] = 8'hD9; serr[1] = 1'b0;
    scol[2] = 12'h280; sdat[2] = 8'hE2; serr[2] = 1'b0;
    scol[3] = 12'h082; sdat[3] = 8'h7A; serr[3] = 1'b0;
    scol[4] = 12'h180; sdat[4] = 8'h3F; serr[4] = 1'b1;
    scol[5] = 12'hE00; sdat[5] = 8'h3F; serr[5] = 1'b1;
    scol[6] = 12'h201; sdat[6] = 8'hE9; serr[6] = 1'b0;
    for (int i = 0; i < 7; i++) slast[i] = (i == 3);
    run_stream(7, "strm");
    check("strm.errcnt", 32'(o_errcnt), 32'd2);

    // Last marking with COLS=4 over 9 columns
    do_reset;
    for (int i = 0; i < 9; i++) begin
      scol[i] = 12'h000; sdat[i] = 8'h40; serr[i] = 1'b0; slast[i] = ((i % 4) == 3);
    end
    run_stream(9, "last");

    // Backpressure: i_ready low for 5 cycles while input keeps coming
    do_reset;
    bc[0] = 12'h100; bc[1] = 12'h080; bc[2] = 12'h040;
    bc[3] = 12'h020; bc[4] = 12'h010; bc[5] = 12'h008;
    n = 0; m = 0;
    for (int c = 0; c < 40; c++) begin
      i_ready = (c >= 5);
      i_valid = (n < 6);
      i_col   = bc[(n < 6) ? n : 0];
      #1;
      acc  = i_valid && o_ready;
      fire = o_valid && i_ready;
      if (c == 4) begin
        check("bp.accepts", 32'(n), 32'd2);
        check("bp.ready", 32'(o_ready), 32'd0);
      end
      if (c >= 2 && c < 5) begin
        check($sformatf("bp.hold%0d", c), 32'(o_data), 32'hF1);
        check($sformatf("bp.holdv%0d", c), 32'(o_valid), 32'd1);
      end
      if (fire) begin
        if (m < 6) check($sformatf("bp.order%0d", m), 32'(o_data), 32'hF1 + 32'(m));
        else check("bp.extra", 32'(o_data), 32'hFFFF);
        m++;
      end
      tick;
      if (acc) n++;
      if (m == 6) break;
    end
    check("bp.count", 32'(m), 32'd6);
    i_valid = 1'b0;
    tick;
    tick;
    check("bp.drained", 32'(o_valid), 32'd0);

    // Clear with two columns in flight
    do_reset;
    i_ready = 1'b1; i_valid = 1'b1; i_col = 12'h900;
    tick;
    i_col = 12'h401;
    tick;
    check("clr.pre", 32'(o_valid), 32'd1);
    i_clr = 1'b1; i_col = 12'hE00;
    tick;
    i_clr = 1'b0; i_valid = 1'b0;
    check("clr.valid", 32'(o_valid), 32'd0);
    check("clr.errcnt", 32'(o_errcnt), 32'd0);
    tick;
    check("clr.flushed", 32'(o_valid), 32'd0);
    scol[0] = 12'h100; sdat[0] = 8'hF1; serr[0] = 1'b0; slast[0] = 1'b0;
    scol[1] = 12'h080; sdat[1] = 8'hF2; serr[1] = 1'b0; slast[1] = 1'b0;
    scol[2] = 12'h040; sdat[2] = 8'hF3; serr[2] = 1'b0; slast[2] = 1'b0;
    scol[3] = 12'h020; sdat[3] = 8'hF4; serr[3] = 1'b0; slast[3] = 1'b1;
    run_stream(4, "clrpost");
    check("clrpost.errcnt", 32'(o_errcnt), 32'd0);

    // Clear coinciding with an invalid output transfer still counts it
    do_reset;
    i_valid = 1'b1; i_col = 12'hE00;
    tick;
    i_valid = 1'b0;
    tick;
    check("clrerr.valid", 32'(o_valid), 32'd1);
    check("clrerr.err", 32'(o_err), 32'd1);
    i_clr = 1'b1;
    tick;
    i_clr = 1'b0;
    check("clrerr.errcnt", 32'(o_errcnt), 32'd1);
    check("clrerr.empty", 32'(o_valid), 32'd0);

    // Reset mid-card, with clear also asserted
    i_valid = 1'b1; i_col = 12'h900;
    tick;
    i_col = 12'h401;
    tick;
    i_rst_n = 1'b0; i_clr = 1'b1;
    tick;
    i_rst_n = 1'b1; i_clr = 1'b0; i_valid = 1'b0;
    check("midrst.valid", 32'(o_valid), 32'd0);
    check("midrst.data", 32'(o_data), 32'h00);
    check("midrst.errcnt", 32'(o_errcnt), 32'd0);
    check("midrst.ready", 32'(o_ready), 32'd1);
    tick;
    tick;
    check("midrst.quiet", 32'(o_valid), 32'd0);

    // Saturation of the 4-bit error counter
    do_reset;
    for (int i = 0; i < 17; i++) begin
      scol[i] = 12'hE00; sdat[i] = 8'h3F; serr[i] = 1'b1; slast[i] = ((i % 4) == 3);
    end
    run_stream(17, "sat");
    check("sat.errcnt", 32'(o_errcnt), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
